// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
//   Assembles framed command packets from the UART receiver byte stream and
//   presents validated commands on a valid/ready interface.
//
//   Packet: SYNC_BYTE, OPCODE, LEN, LEN payload bytes, CHK
//   CHK = XOR of OPCODE, LEN and every payload byte (SYNC excluded).
//
// Ports
//   CLK            system clock
//   rst_n          asynchronous active-low reset
//   rx_data        received byte (UART rx data_out)
//   rx_valid       one-cycle byte strobe
//   rx_ferr        one-cycle framing-error strobe
//   cmd_valid      command available (held until cmd_ready)
//   cmd_ready      consumer accepts command
//   cmd_opcode     command opcode
//   cmd_len        payload length
//   cmd_payload    payload, byte i at [8i+7:8i], bytes >= cmd_len are zero
//   err_chk        one-cycle pulse: checksum mismatch
//   err_len        one-cycle pulse: LEN > MAX_LEN
//   err_abort      one-cycle pulse: framing error or inter-byte timeout
//   err_ovr        one-cycle pulse: byte dropped while a command is held
//
// Optional build macro UART_PARSER_ERRCNT_EN adds:
//   err_count_clr  synchronous clear of err_count (wins over increment)
//   err_count      saturating 16-bit count of all err_* pulses
// -----------------------------------------------------------------------------
module uart_cmd_parser #(
  parameter int         MAX_LEN     = 8,
  parameter int         TIMEOUT_CYC = 50000,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  localparam int        LW          = $clog2(MAX_LEN + 1)
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic                 rx_ferr,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [7:0]           cmd_opcode,
  output logic [LW-1:0]        cmd_len,
  output logic [8*MAX_LEN-1:0] cmd_payload,
  output logic                 err_chk,
  output logic                 err_len,
  output logic                 err_abort,
`ifdef UART_PARSER_ERRCNT_EN
  input  logic                 err_count_clr,
  output logic [15:0]          err_count,
`endif
  output logic                 err_ovr
);

  localparam int GW = $clog2(TIMEOUT_CYC + 1);
  // Abort fires on the idle cycle that would take the gap count to TIMEOUT_CYC.
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_SYNC, S_OP, S_LEN, S_PAY, S_CHK, S_HOLD
  } state_t;

  state_t               state_reg, state_next;
  logic [7:0]           op_reg, op_next;
  logic [LW-1:0]        len_reg, len_next;
  logic [LW-1:0]        idx_reg, idx_next;
  logic [7:0]           chk_reg, chk_next;
  logic [8*MAX_LEN-1:0] shadow_reg, shadow_next;
  logic [GW-1:0]        gap_reg, gap_next;

  logic                 cmd_valid_next;
  logic [7:0]           cmd_opcode_next;
  logic [LW-1:0]        cmd_len_next;
  logic [8*MAX_LEN-1:0] cmd_payload_next;
  logic                 err_chk_next, err_len_next, err_abort_next, err_ovr_next;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_SYNC;
      op_reg      <= '0;
      len_reg     <= '0;
      idx_reg     <= '0;
      chk_reg     <= '0;
      shadow_reg  <= '0;
      gap_reg     <= '0;
      cmd_valid   <= 1'b0;
      cmd_opcode  <= '0;
      cmd_len     <= '0;
      cmd_payload <= '0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_abort   <= 1'b0;
      err_ovr     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      op_reg      <= op_next;
      len_reg     <= len_next;
      idx_reg     <= idx_next;
      chk_reg     <= chk_next;
      shadow_reg  <= shadow_next;
      gap_reg     <= gap_next;
      cmd_valid   <= cmd_valid_next;
      cmd_opcode  <= cmd_opcode_next;
      cmd_len     <= cmd_len_next;
      cmd_payload <= cmd_payload_next;
      err_chk     <= err_chk_next;
      err_len     <= err_len_next;
      err_abort   <= err_abort_next;
      err_ovr     <= err_ovr_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    op_next          = op_reg;
    len_next         = len_reg;
    idx_next         = idx_reg;
    chk_next         = chk_reg;
    shadow_next      = shadow_reg;
    gap_next         = gap_reg;
    cmd_valid_next   = cmd_valid;
    cmd_opcode_next  = cmd_opcode;
    cmd_len_next     = cmd_len;
    cmd_payload_next = cmd_payload;
    err_chk_next     = 1'b0;
    err_len_next     = 1'b0;
    err_abort_next   = 1'b0;
    err_ovr_next     = 1'b0;

    case (state_reg)
      S_SYNC: begin
        gap_next = '0;
        if (rx_valid && rx_data == SYNC_BYTE) state_next = S_OP;
      end

      S_HOLD: begin
        gap_next = '0;
        if (cmd_ready) begin
          // Handshake completes; a byte arriving now is treated as a sync candidate.
          cmd_valid_next = 1'b0;
          state_next     = (rx_valid && rx_data == SYNC_BYTE) ? S_OP : S_SYNC;
        end else if (rx_valid) begin
          err_ovr_next = 1'b1;
        end
      end

      default: begin
        // In-packet states S_OP..S_CHK share abort and timeout handling.
        if (rx_ferr) begin
          err_abort_next = 1'b1;
          gap_next       = '0;
          state_next     = S_SYNC;
        end else if (rx_valid) begin
          gap_next = '0;
          case (state_reg)
            S_OP: begin
              op_next     = rx_data;
              chk_next    = rx_data;
              shadow_next = '0;   // guarantees zero-fill above len
              state_next  = S_LEN;
            end
            S_LEN: begin
              if (rx_data > 8'(MAX_LEN)) begin
                err_len_next = 1'b1;
                state_next   = S_SYNC;
              end else begin
                len_next   = rx_data[LW-1:0];
                chk_next   = chk_reg ^ rx_data;
                idx_next   = '0;
                state_next = (rx_data == 8'd0) ? S_CHK : S_PAY;
              end
            end
            S_PAY: begin
              for (int i = 0; i < MAX_LEN; i++) begin
                if (idx_reg == LW'(i)) shadow_next[8*i +: 8] = rx_data;
              end
              chk_next = chk_reg ^ rx_data;
              if (idx_reg == len_reg - LW'(1)) state_next = S_CHK;
              else                             idx_next   = idx_reg + LW'(1);
            end
            S_CHK: begin
              if (rx_data == chk_reg) begin
                cmd_valid_next   = 1'b1;
                cmd_opcode_next  = op_reg;
                cmd_len_next     = len_reg;
                cmd_payload_next = shadow_reg;
                state_next       = S_HOLD;
              end else begin
                err_chk_next = 1'b1;
                state_next   = S_SYNC;
              end
            end
            default: state_next = S_SYNC;
          endcase
        end else if (gap_reg == GAP_LAST) begin
          err_abort_next = 1'b1;
          gap_next       = '0;
          state_next     = S_SYNC;
        end else begin
          gap_next = gap_reg + GW'(1);
        end
      end
    endcase
  end

`ifdef UART_PARSER_ERRCNT_EN
  // The err_* sources are mutually exclusive, so at most one increment per cycle.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_count_clr) begin
      err_count <= '0;
    end else if ((err_chk | err_len | err_abort | err_ovr) && err_count != 16'hFFFF) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
module tb_uart_cmd_parser;

  localparam int MAXL = 8;
  localparam int TO   = 50000;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ferr, cmd_ready;
  logic        cmd_valid;
  logic [7:0]  cmd_opcode;
  logic [3:0]  cmd_len;
  logic [63:0] cmd_payload;
  logic        err_chk, err_len, err_abort, err_ovr;
`ifdef UART_PARSER_ERRCNT_EN
  logic        err_count_clr = 1'b0;
  logic [15:0] err_count;
`endif

  uart_cmd_parser #(.MAX_LEN(MAXL), .TIMEOUT_CYC(TO), .SYNC_BYTE(8'hA5)) dut (
    .CLK(CLK), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_len(cmd_len), .cmd_payload(cmd_payload),
    .err_chk(err_chk), .err_len(err_len), .err_abort(err_abort),
`ifdef UART_PARSER_ERRCNT_EN
    .err_count_clr(err_count_clr), .err_count(err_count),
`endif
    .err_ovr(err_ovr)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_chk = 0, cnt_len = 0, cnt_abort = 0, cnt_ovr = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- packet-level reference model ----------------
  // Tracks the bytes of the current packet as a list and applies the framing
  // rules to the whole list whenever a byte arrives.
  bit          m_hold, m_in;
  int          m_idle;
  logic [7:0]  m_pkt[$];
  logic [7:0]  m_x;
  logic        e_valid, e_chk, e_lenerr, e_abort, e_ovr;
  logic [7:0]  e_op;
  logic [3:0]  e_len;
  logic [63:0] e_pay;

  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      m_hold = 0; m_in = 0; m_idle = 0; m_pkt.delete();
      e_valid = 0; e_chk = 0; e_lenerr = 0; e_abort = 0; e_ovr = 0;
      e_op = 0; e_len = 0; e_pay = 0;
    end else begin
      e_chk = 0; e_lenerr = 0; e_abort = 0; e_ovr = 0;
      if (m_hold) begin
        if (cmd_ready) begin
          e_valid = 0; m_hold = 0;
          if (rx_valid && rx_data == 8'hA5) begin m_in = 1; m_pkt.delete(); m_idle = 0; end
        end else if (rx_valid) begin
          e_ovr = 1;
        end
      end else if (!m_in) begin
        if (rx_valid && rx_data == 8'hA5) begin m_in = 1; m_pkt.delete(); m_idle = 0; end
      end else if (rx_ferr) begin
        e_abort = 1; m_in = 0;
      end else if (rx_valid) begin
        m_idle = 0;
        m_pkt.push_back(rx_data);
        if (m_pkt.size() == 2 && int'(m_pkt[1]) > MAXL) begin
          e_lenerr = 1; m_in = 0;
        end else if (m_pkt.size() >= 2 && m_pkt.size() == int'(m_pkt[1]) + 3) begin
          m_x = 8'h00;
          for (int i = 0; i < m_pkt.size() - 1; i++) m_x = m_x ^ m_pkt[i];
          if (m_x == m_pkt[m_pkt.size()-1]) begin
            e_valid = 1; e_op = m_pkt[0]; e_len = m_pkt[1][3:0]; e_pay = 0;
            for (int i = 0; i < int'(m_pkt[1]); i++) e_pay[8*i +: 8] = m_pkt[2+i];
            m_hold = 1;
          end else begin
            e_chk = 1;
          end
          m_in = 0;
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin e_abort = 1; m_in = 0; end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    check("cmd_valid", 64'(cmd_valid), 64'(e_valid));
    check("err_chk",   64'(err_chk),   64'(e_chk));
    check("err_len",   64'(err_len),   64'(e_lenerr));
    check("err_abort", 64'(err_abort), 64'(e_abort));
    check("err_ovr",   64'(err_ovr),   64'(e_ovr));
    if (e_valid) begin
      check("cmd_opcode",  64'(cmd_opcode), 64'(e_op));
      check("cmd_len",     64'(cmd_len),    64'(e_len));
      check("cmd_payload", cmd_payload,     e_pay);
    end
    if (err_chk)   cnt_chk++;
    if (err_len)   cnt_len++;
    if (err_abort) cnt_abort++;
    if (err_ovr)   cnt_ovr++;
  end

  // ---------------- stimulus (all tasks start and end at a negedge) ----------------
  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  task automatic send_seq(input logic [7:0] s[]);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic send_ferr();
    rx_ferr = 1'b1;
    @(negedge CLK);
    rx_ferr = 1'b0;
  endtask

  task automatic expect_cmd(input string nm, input logic [7:0] op, input logic [3:0] ln,
                            input logic [63:0] pay);
    $display("cmd %s: valid=%0b op=%02h len=%0d payload=%016h", nm, cmd_valid, cmd_opcode, cmd_len, cmd_payload);
    check({nm, ".valid"},   64'(cmd_valid),  64'd1);
    check({nm, ".opcode"},  64'(cmd_opcode), 64'(op));
    check({nm, ".len"},     64'(cmd_len),    64'(ln));
    check({nm, ".payload"}, cmd_payload,     pay);
  endtask

  int errs0;

  initial begin
    rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_ferr = 1'b0; cmd_ready = 1'b1;
    repeat (3) @(negedge CLK);
    check("reset.valid",   64'(cmd_valid),  64'd0);
    check("reset.opcode",  64'(cmd_opcode), 64'd0);
    check("reset.len",     64'(cmd_len),    64'd0);
    check("reset.payload", cmd_payload,     64'd0);
    check("reset.errs",    64'({err_chk, err_len, err_abort, err_ovr}), 64'd0);
    rst_n = 1'b1;
    @(negedge CLK);

    // T1: good packet, consumer ready
    errs0 = cnt_chk + cnt_len + cnt_abort + cnt_ovr;
    send_seq('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21});
    expect_cmd("t1", 8'h10, 4'd2, 64'h2211);
    @(negedge CLK);
    check("t1.one_cycle", 64'(cmd_valid), 64'd0);
    #1 check("t1.no_err", 64'(cnt_chk + cnt_len + cnt_abort + cnt_ovr - errs0), 64'd0);
    @(negedge CLK);

    // T2: bad checksum, then zero-length packet
    send_seq('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20});
    $display("t2 bad chk: err_chk=%0b cmd_valid=%0b", err_chk, cmd_valid);
    check("t2.err_chk", 64'(err_chk),   64'd1);
    check("t2.novalid", 64'(cmd_valid), 64'd0);
    send_seq('{8'hA5, 8'h05, 8'h00, 8'h05});
    expect_cmd("t2", 8'h05, 4'd0, 64'h0);
    @(negedge CLK);

    // T3: LEN too large, then a one-byte packet
    send_seq('{8'hA5, 8'h07, 8'h09});
    $display("t3 len err: err_len=%0b", err_len);
    check("t3.err_len", 64'(err_len), 64'd1);
    send_seq('{8'hA5, 8'h07, 8'h01, 8'hAA, 8'hAC});
    expect_cmd("t3", 8'h07, 4'd1, 64'hAA);
    @(negedge CLK);

    // T4: framing abort, then inter-byte timeout
    send_seq('{8'hA5, 8'h10, 8'h02, 8'h11});
    send_ferr();
    $display("t4 ferr: err_abort=%0b", err_abort);
    check("t4.ferr_abort", 64'(err_abort), 64'd1);
    @(negedge CLK);
    send_seq('{8'hA5, 8'h10});
    repeat (TO - 1) @(negedge CLK);
    check("t4.no_abort_early", 64'(err_abort), 64'd0);
    @(negedge CLK);
    $display("t4 timeout: err_abort=%0b after %0d idle cycles", err_abort, TO);
    check("t4.timeout_abort", 64'(err_abort), 64'd1);
    @(negedge CLK);

    // T5: held command, overruns, then handshake concurrent with a SYNC byte
    cmd_ready = 1'b0;
    send_seq('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21});
    errs0 = cnt_ovr;
    send_seq('{8'h33, 8'h44, 8'h55});
    #1 $display("t5 overruns: %0d", cnt_ovr - errs0);
    check("t5.ovr_count", 64'(cnt_ovr - errs0), 64'd3);
    expect_cmd("t5.held", 8'h10, 4'd2, 64'h2211);
    @(negedge CLK);
    cmd_ready = 1'b1;
    send_byte(8'hA5);
    check("t5.handshake", 64'(cmd_valid), 64'd0);
    send_seq('{8'h05, 8'h00, 8'h05});   // no SYNC: parser must already be in S_OP
    expect_cmd("t5.after", 8'h05, 4'd0, 64'h0);
    @(negedge CLK);

    // T6: asynchronous reset mid-payload, then recovery
    send_seq('{8'hA5, 8'h10, 8'h03, 8'h11});
    #2 rst_n = 1'b0;
    #1;
    $display("t6 async reset: valid=%0b op=%02h len=%0d pay=%0h", cmd_valid, cmd_opcode, cmd_len, cmd_payload);
    check("t6.valid",   64'(cmd_valid),  64'd0);
    check("t6.opcode",  64'(cmd_opcode), 64'd0);
    check("t6.len",     64'(cmd_len),    64'd0);
    check("t6.payload", cmd_payload,     64'd0);
    @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);
    send_seq('{8'hA5, 8'h20, 8'h03, 8'h01, 8'h02, 8'h03, 8'h23});
    expect_cmd("t6.recover", 8'h20, 4'd3, 64'h030201);
    repeat (3) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
